// File: rtl/binario_a_bcd.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble, fixed 15-clock latency).
// Optional build macro: BCD_BLANK_LEADING_EN blanks leading-zero digits (code 4'hF).
module binario_a_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] binario,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  unidades,
  output logic [3:0]  decenas,
  output logic [3:0]  centenas,
  output logic [3:0]  unidadesMillar,
  output logic [1:0]  dbg_state
);

  // Handshake: start is sampled only while IDLE; busy marks the conversion and
  // done pulses for one cycle when the digit outputs change.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [13:0] MAX_BCD  = 14'd9999;
  localparam logic [3:0]  LAST_IT  = 4'd13;
  localparam logic [15:0] HI_CODE  = 16'hAAAA;
`ifdef BCD_BLANK_LEADING_EN
  localparam logic [15:0] RST_DIG  = 16'hFFF0;
`else
  localparam logic [15:0] RST_DIG  = 16'h0000;
`endif

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] dig_q, dig_d;
  logic [15:0] bcd_adj;

`ifdef BCD_BLANK_LEADING_EN
  function automatic logic [15:0] to_display(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    if (b[15:12] == 4'd0) r[15:12] = 4'hF;
    if (b[15:8] == 8'd0)  r[11:8]  = 4'hF;
    if (b[15:4] == 12'd0) r[7:4]   = 4'hF;
    return r;
  endfunction
`else
  function automatic logic [15:0] to_display(input logic [15:0] b);
    return b;
  endfunction
`endif

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dig_d   = dig_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = binario;
          bcd_d   = 16'd0;
          cnt_d   = 4'd0;
          ovf_d   = (binario > MAX_BCD);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A carry out of the top nibble can only come from an out-of-range value.
        bcd_d = {bcd_adj[14:0], bin_q[13]};
        bin_d = {bin_q[12:0], 1'b0};
        ovf_d = ovf_q | bcd_adj[15];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_IT) state_d = FIN;
      end
      FIN: begin
        dig_d   = ovf_q ? HI_CODE : to_display(bcd_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= 14'd0;
      bcd_q   <= 16'd0;
      cnt_q   <= 4'd0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dig_q   <= RST_DIG;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dig_q   <= dig_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign unidades       = dig_q[3:0];
  assign decenas        = dig_q[7:4];
  assign centenas       = dig_q[11:8];
  assign unidadesMillar = dig_q[15:12];
  assign dbg_state      = state_q;

endmodule

// File: doc/binario_a_bcd.md
BINARIO_A_BCD -- requirements
Module: binario_a_bcd

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have port binario, input, 14 bits: unsigned value to convert, sampled only when a start is accepted.
REQ-004 The block SHALL have port start, input, 1 bit: conversion request, sampled on the rising edge of clk.
REQ-005 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-006 The block SHALL have port done, output, 1 bit: one-cycle pulse when the new digits are valid.
REQ-007 The block SHALL have ports unidades, decenas, centenas and unidadesMillar, each output, 4 bits: registered digit codes that directly drive the 4-digit 7-segment display controller.

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, SHIFT and FIN.
REQ-009 In IDLE with start=1 at edge E0, the block SHALL capture binario, clear the BCD scratch register, set the iteration counter to 0, assert busy and enter SHIFT.
REQ-010 Each SHIFT cycle SHALL add 3 to every scratch nibble that is >=5, then shift the scratch register left by one with the next binario MSB entering at the bottom (double-dabble); exactly 14 iterations SHALL occur, at edges E1..E14.
REQ-011 At E15 the block SHALL load all four digit outputs together, pulse done high for exactly one cycle, drop busy (state FIN) and return to IDLE at E16.
REQ-012 The latency SHALL be fixed at 15 clocks from start acceptance to done, independent of the value of binario.
REQ-013 Between done pulses the digit outputs SHALL hold their last values; no intermediate scratch value SHALL ever appear on them.
REQ-014 If the captured binario is >9999, the block SHALL force all four digits to 4'd10 at E15, with the same latency, so the display shows "HI".
REQ-015 start while busy=1 or in FIN SHALL be ignored and SHALL NOT be queued.
REQ-016 A new start in the IDLE cycle immediately after FIN SHALL be accepted normally (back-to-back period of 16 clocks).
REQ-017 Digit values 11-15 SHALL be produced only by the blanking feature in REQ-022.

Reset
REQ-018 With rst_n=0 at a rising edge, the block SHALL enter IDLE with busy=0, done=0 and the iteration counter and scratch register cleared.
REQ-019 Under the same reset, unidades, decenas, centenas and unidadesMillar SHALL reset to 0, except for the blanking override given in REQ-022.
REQ-020 A reset applied mid-conversion SHALL abort the conversion without producing a done pulse; the partial result SHALL be discarded.
REQ-021 The first start SHALL be accepted no earlier than the first edge with rst_n=1.

Configuration
REQ-022 When BCD_BLANK_LEADING_EN is defined, each leading-zero digit among unidadesMillar, centenas and decenas SHALL be output as 4'hF (blank); unidades SHALL always show its digit; the reset values of unidadesMillar, centenas and decenas SHALL be 4'hF; the overflow code 10 SHALL be unaffected.
REQ-023 When BCD_BLANK_LEADING_EN is not defined, all digits SHALL be output as plain BCD, including leading zeros.

Verification
REQ-024 A bench SHALL apply binario=1234 with start at E0 -> at E15, done=1 for one cycle with unidadesMillar=1, centenas=2, decenas=3, unidades=4; busy=1 from E0 through E14.
REQ-025 A bench SHALL apply binario=9999 and then binario=10000 -> first result 9,9,9,9; second result all four digits =10, each with 15-clock latency.
REQ-026 A bench SHALL apply binario=0 and binario=7 -> without the macro, 0,0,0,0 and 0,0,0,7; with BCD_BLANK_LEADING_EN, F,F,F,0 and F,F,F,7.
REQ-027 A bench SHALL start with 42, pulse start with binario=500 at E5, then start again at E16 with 500 -> E5 request ignored; E15 outputs 0,0,4,2; E31 outputs 0,5,0,0.
REQ-028 A bench SHALL start with 8888 and assert rst_n=0 at E7 -> no done pulse; busy=0 and digits at reset values after that edge; a new start of 8888 then completes in 15 clocks.
